vedic_mult_pipe_param: RTL

//  Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with valid/ready flow control.

---
 rtl/vedic_mult_pipe_param_pkg.sv | 49 ++++
 rtl/vedic_mult_pipe_param_if.sv | 28 ++
 rtl/vedic_mult_pipe_param_level.sv | 83 ++++++++
 rtl/vedic_mult_pipe_param.sv | 127 ++++++++++++
 4 files changed

// File: rtl/vedic_mult_pipe_param_pkg.sv
// Purpose: shared helpers for the pipelined Vedic multiplier (widths, latency, 4x4 cell, tree indexing).
// Latency: n/a (package of constant functions and a combinational 4x4 cell).
// Backpressure: n/a.
package vedic_pkg;

  localparam int MIN_WIDTH = 8;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  function automatic int vedic_lat(input int width);
    return 2 + 3 * clog2(width / 4);
  endfunction

  // Urdhva-Tiryagbhyam 4x4 cell: column k collects every a[i]*b[j] with i+j == k
  // (vertical and crosswise), columns are then weighted and summed.
  function automatic logic [7:0] vedic4(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] acc;
    logic [7:0] col_sum;
    acc = '0;
    for (int col = 0; col < 7; col++) begin
      col_sum = '0;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++) begin
          if (i + j == col) col_sum = col_sum + {7'b0, a[i] & b[j]};
        end
      end
      acc = acc + (col_sum << col);
    end
    return acc;
  endfunction

  // Position of the 4x4 cell for digit pair (i, j) in the flat partial-product vector.
  // Each 2-bit group is one recursion level (lowest group = finest level), encoded as
  // 2*a_half + b_half, so siblings ll/lh/hl/hh of every tree node sit next to each other.
  function automatic int morton(input int i, input int j, input int levels);
    int idx;
    idx = 0;
    for (int t = 0; t < levels; t++) begin
      idx = idx + ((((i >> t) & 1) * 2 + ((j >> t) & 1)) << (2 * t));
    end
    return idx;
  endfunction

endpackage

// File: rtl/vedic_mult_pipe_param_if.sv
// Purpose: operand/product handshake bundle for vedic_mult_pipe_param.
// Latency: n/a (wires only). master = operand producer / product consumer, slave = multiplier.
// Backpressure: in_valid/in_ready on the operand side, out_valid/out_ready on the product side.
interface vedic_mult_pipe_param_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_signed;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_p;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    input  in_ready, out_valid, out_p, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
    output in_ready, out_valid, out_p, out_tag
  );
endinterface

// File: rtl/vedic_mult_pipe_param_level.sv
// Purpose: one recursion level; merges NODES groups of four HALFxHALF products into 2HALFx2HALF products.
// Latency: 3 cycles (cross add, middle add, high add), sideband delayed alongside.
// Backpressure: every register loads only when adv = 1, otherwise the whole level holds.
// Ports: clk1/rst_n, adv enable, pp_in (4 products of 2*HALF bits per node, ll/lh/hl/hh),
//        vld/neg/tag in and out, p_out (one 4*HALF-bit product per node).
module vedic_pipe_level #(
  parameter int HALF  = 4,
  parameter int NODES = 1,
  parameter int TAG_W = 4
) (
  input  logic                       clk1,
  input  logic                       rst_n,
  input  logic                       adv,
  input  logic [4*NODES*2*HALF-1:0]  pp_in,
  input  logic                       vld_in,
  input  logic                       neg_in,
  input  logic [TAG_W-1:0]           tag_in,
  output logic [NODES*4*HALF-1:0]    p_out,
  output logic                       vld_out,
  output logic                       neg_out,
  output logic [TAG_W-1:0]           tag_out
);
  localparam int PW = 2 * HALF;

  logic [2:0]            vld_q;
  logic [2:0]            neg_q;
  logic [2:0][TAG_W-1:0] tag_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      neg_q <= '0;
      tag_q <= '0;
    end else if (adv) begin
      vld_q <= {vld_q[1:0], vld_in};
      neg_q <= {neg_q[1:0], neg_in};
      tag_q <= {tag_q[1:0], tag_in};
    end
  end

  assign vld_out = vld_q[2];
  assign neg_out = neg_q[2];
  assign tag_out = tag_q[2];

  for (genvar n = 0; n < NODES; n++) begin : g_node
    logic [PW-1:0] ll, lh, hl, hh;
    assign ll = pp_in[(4*n+0)*PW +: PW];
    assign lh = pp_in[(4*n+1)*PW +: PW];
    assign hl = pp_in[(4*n+2)*PW +: PW];
    assign hh = pp_in[(4*n+3)*PW +: PW];

    logic [PW:0]     s1_cross;
    logic [PW-1:0]   s1_ll, s1_hh;
    logic [PW:0]     s2_mid;
    logic [HALF-1:0] s2_lo;
    logic [PW-1:0]   s2_hh;
    logic [2*PW-1:0] s3_p;

    // product = hh<<2H + (lh+hl)<<H + ll; one adder per stage, ll's low half and hh ride
    // delay registers until they are needed. mid cannot overflow PW+1 bits.
    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
        s1_cross <= '0;
        s1_ll    <= '0;
        s1_hh    <= '0;
        s2_mid   <= '0;
        s2_lo    <= '0;
        s2_hh    <= '0;
        s3_p     <= '0;
      end else if (adv) begin
        s1_cross <= {1'b0, lh} + {1'b0, hl};
        s1_ll    <= ll;
        s1_hh    <= hh;
        s2_mid   <= s1_cross + {{(HALF+1){1'b0}}, s1_ll[PW-1:HALF]};
        s2_lo    <= s1_ll[HALF-1:0];
        s2_hh    <= s1_hh;
        s3_p     <= {s2_hh + {{(HALF-1){1'b0}}, s2_mid[PW:HALF]}, s2_mid[HALF-1:0], s2_lo};
      end
    end

    assign p_out[n*2*PW +: 2*PW] = s3_p;
  end
endmodule

// File: rtl/vedic_mult_pipe_param.sv
// Purpose: pipelined signed/unsigned Vedic multiplier with tag sideband (clk1, rst_n, io slave bundle).
// Latency: 2 + 3*log2(WIDTH/4) cycles from accept to out_valid (5 at WIDTH=8, 8 at WIDTH=16).
// Backpressure: in_ready = !out_valid | out_ready; when low, every stage holds (full-pipe stall).
module vedic_mult_pipe_param
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  vedic_mult_pipe_param_if.slave  io
);
  localparam int LEVELS = clog2(WIDTH / 4);
  localparam int DIG    = WIDTH / 4;
  localparam int PPW    = DIG * DIG * 8;

  if (WIDTH < MIN_WIDTH || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("vedic_mult_pipe_param: WIDTH must be a power of two and at least 8");
  end

  logic adv;
  logic out_vld_q;
  logic [2*WIDTH-1:0] out_p_q;
  logic [TAG_W-1:0]   out_tag_q;

  assign adv         = !out_vld_q || io.out_ready;
  assign io.in_ready = adv;

  // Signed operands are reduced to magnitudes; -2^(W-1) negates to itself, which is the
  // correct unsigned magnitude 2^(W-1).
  logic sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sa    = io.in_signed & io.in_a[WIDTH-1];
  assign sb    = io.in_signed & io.in_b[WIDTH-1];
  assign a_mag = sa ? -io.in_a : io.in_a;
  assign b_mag = sb ? -io.in_b : io.in_b;

  logic [PPW-1:0] pp_c;
  for (genvar i = 0; i < DIG; i++) begin : g_ai
    for (genvar j = 0; j < DIG; j++) begin : g_bj
      assign pp_c[morton(i, j, LEVELS)*8 +: 8] = vedic4(a_mag[4*i +: 4], b_mag[4*j +: 4]);
    end
  end

  logic [PPW-1:0]   pp_q;
  logic             vld1_q, neg1_q;
  logic [TAG_W-1:0] tag1_q;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pp_q   <= '0;
      vld1_q <= 1'b0;
      neg1_q <= 1'b0;
      tag1_q <= '0;
    end else if (adv) begin
      pp_q   <= pp_c;
      vld1_q <= io.in_valid;
      neg1_q <= sa ^ sb;
      tag1_q <= io.in_tag;
    end
  end

  // Level k merges 4-bit-digit products into 2^(k+3)-bit operand products; the input
  // width of level k equals the output width of level k-1, so levels chain directly.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int HALF  = 4 << k;
    localparam int NODES = 1 << (2 * (LEVELS - 1 - k));

    logic [4*NODES*2*HALF-1:0] src;
    logic                      src_vld, src_neg;
    logic [TAG_W-1:0]          src_tag;
    logic [NODES*4*HALF-1:0]   p;
    logic                      vld, neg;
    logic [TAG_W-1:0]          tag;

    if (k == 0) begin : g_src
      assign src     = pp_q;
      assign src_vld = vld1_q;
      assign src_neg = neg1_q;
      assign src_tag = tag1_q;
    end else begin : g_src
      assign src     = g_lvl[k-1].p;
      assign src_vld = g_lvl[k-1].vld;
      assign src_neg = g_lvl[k-1].neg;
      assign src_tag = g_lvl[k-1].tag;
    end

    vedic_pipe_level #(.HALF(HALF), .NODES(NODES), .TAG_W(TAG_W)) u_level (
      .clk1    (clk1),
      .rst_n   (rst_n),
      .adv     (adv),
      .pp_in   (src),
      .vld_in  (src_vld),
      .neg_in  (src_neg),
      .tag_in  (src_tag),
      .p_out   (p),
      .vld_out (vld),
      .neg_out (neg),
      .tag_out (tag)
    );
  end

  logic [2*WIDTH-1:0] mag;
  logic               last_vld, last_neg;
  logic [TAG_W-1:0]   last_tag;
  assign mag      = g_lvl[LEVELS-1].p;
  assign last_vld = g_lvl[LEVELS-1].vld;
  assign last_neg = g_lvl[LEVELS-1].neg;
  assign last_tag = g_lvl[LEVELS-1].tag;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q <= 1'b0;
      out_p_q   <= '0;
      out_tag_q <= '0;
    end else if (adv) begin
      out_vld_q <= last_vld;
      out_p_q   <= last_neg ? -mag : mag;
      out_tag_q <= last_tag;
    end
  end

  assign io.out_valid = out_vld_q;
  assign io.out_p     = out_p_q;
  assign io.out_tag   = out_tag_q;
endmodule
